// File: rtl/pfb_pkg.sv
// Shared constants and write-FSM encoding for the PFB -> FFT front end.
package pfb_pkg;

  localparam int DATA_WIDTH = 36;
  localparam int FFT_SIZE_W = 10;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    W_SOF    = 2'd0,
    W_ACCEPT = 2'd1,
    W_DROP   = 2'd2
  } wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port RAM: write on port A, registered 1-cycle read on port B.
module frame_fifo_ram #(
  parameter int WIDTH      = 37,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/circ_frame_fifo.sv
// Frame-aware FIFO: stores whole frames, drops frames that cannot fit at start.
// Optional macro CIRC_FRAME_LEN_CHECK_EN rolls back frames whose length != latched fft_size.
module circ_frame_fifo #(
  parameter int DATA_WIDTH = pfb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          sync_reset_n,
  input  logic [pfb_pkg::FFT_SIZE_W-1:0] fft_size,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          drop_pulse,
  output logic [15:0]                   frames_dropped,
  output logic [ADDR_WIDTH:0]           fill_level
);
  import pfb_pkg::*;

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  wr_state_t       wr_state_reg;
  logic [PW-1:0]   wr_ptr_reg, wr_commit_reg, rd_ptr_reg;
  logic            commit_pending_reg;
  logic            drop_pulse_reg;
  logic [15:0]     frames_dropped_reg;
  logic [PW-1:0]   fill_level_reg;

  logic [PW-1:0]   used_beats, free_beats;
  logic            fits, ram_we, len_short, len_long, len_err;

`ifdef CIRC_FRAME_LEN_CHECK_EN
  localparam logic [FFT_SIZE_W-1:0] CNT_ONE = {{(FFT_SIZE_W-1){1'b0}}, 1'b1};
  logic [FFT_SIZE_W-1:0] frame_len_reg, beat_cnt_reg, beat_num, cur_len;
`endif

  logic                  out_valid_reg, out_last_reg, skid_valid_reg, ram_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DATA_WIDTH:0]   skid_reg, ram_rd_data;
  logic                  avail, pop, rd_issue;
  logic [1:0]            inflight;

  assign used_beats = wr_ptr_reg - rd_ptr_reg;
  assign free_beats = DEPTH - used_beats;

  always_comb begin
    fits      = 32'(free_beats) >= 32'(fft_size);
    ram_we    = s_axis_tvalid &&
                ((wr_state_reg == W_SOF && fits) || wr_state_reg == W_ACCEPT);
    len_short = 1'b0;
    len_long  = 1'b0;
`ifdef CIRC_FRAME_LEN_CHECK_EN
    beat_num  = (wr_state_reg == W_SOF) ? CNT_ONE : beat_cnt_reg + CNT_ONE;
    cur_len   = (wr_state_reg == W_SOF) ? fft_size : frame_len_reg;
    len_short = s_axis_tlast && (beat_num != cur_len);
    len_long  = !s_axis_tlast && (beat_num == cur_len);
`endif
    len_err   = len_short || len_long;
  end

  // Commit lands one cycle after tlast; a frame may start in that same cycle.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      wr_state_reg       <= W_SOF;
      wr_ptr_reg         <= '0;
      wr_commit_reg      <= '0;
      commit_pending_reg <= 1'b0;
      drop_pulse_reg     <= 1'b0;
      frames_dropped_reg <= '0;
`ifdef CIRC_FRAME_LEN_CHECK_EN
      frame_len_reg      <= '0;
      beat_cnt_reg       <= '0;
`endif
    end else begin
      drop_pulse_reg     <= 1'b0;
      commit_pending_reg <= 1'b0;
      if (commit_pending_reg) wr_commit_reg <= wr_ptr_reg;
      if (s_axis_tvalid) begin
        case (wr_state_reg)
          W_SOF, W_ACCEPT: begin
            if (wr_state_reg == W_SOF && !fits) begin
              drop_pulse_reg     <= 1'b1;
              frames_dropped_reg <= sat_inc16(frames_dropped_reg);
              wr_state_reg       <= s_axis_tlast ? W_SOF : W_DROP;
            end else if (len_err) begin
              // Only ACCEPT has advanced wr_ptr, and its wr_commit is never stale.
              if (wr_state_reg == W_ACCEPT) wr_ptr_reg <= wr_commit_reg;
              drop_pulse_reg     <= 1'b1;
              frames_dropped_reg <= sat_inc16(frames_dropped_reg);
              wr_state_reg       <= len_long ? W_DROP : W_SOF;
            end else begin
              wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
`ifdef CIRC_FRAME_LEN_CHECK_EN
              beat_cnt_reg <= beat_num;
              if (wr_state_reg == W_SOF) frame_len_reg <= fft_size;
`endif
              if (s_axis_tlast) begin
                commit_pending_reg <= 1'b1;
                wr_state_reg       <= W_SOF;
              end else begin
                wr_state_reg       <= W_ACCEPT;
              end
            end
          end
          W_DROP: if (s_axis_tlast) wr_state_reg <= W_SOF;
          default: wr_state_reg <= W_SOF;
        endcase
      end
    end
  end

  frame_fifo_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Beats fetched but not yet accepted downstream never exceed the 2-entry skid.
  assign avail    = wr_commit_reg != rd_ptr_reg;
  assign pop      = out_valid_reg && m_axis_tready;
  assign inflight = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, ram_valid_reg};
  assign rd_issue = avail && ((inflight < 2'd2) || (inflight == 2'd2 && pop));

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      rd_ptr_reg     <= '0;
      ram_valid_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
    end else begin
      ram_valid_reg <= rd_issue;
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (!out_valid_reg || m_axis_tready) begin
        if (skid_valid_reg) begin
          {out_last_reg, out_data_reg} <= skid_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= ram_valid_reg;
          if (ram_valid_reg) skid_reg <= ram_rd_data;
        end else if (ram_valid_reg) begin
          {out_last_reg, out_data_reg} <= ram_rd_data;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (ram_valid_reg) begin
        skid_reg       <= ram_rd_data;
        skid_valid_reg <= 1'b1;
      end
    end
  end

  // Prefetched beats still count as unread until the FFT takes them.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) fill_level_reg <= '0;
    else fill_level_reg <= wr_commit_reg - rd_ptr_reg + {{(PW-2){1'b0}}, inflight};
  end

  assign m_axis_tdata   = out_data_reg;
  assign m_axis_tvalid  = out_valid_reg;
  assign m_axis_tlast   = out_last_reg;
  assign drop_pulse     = drop_pulse_reg;
  assign frames_dropped = frames_dropped_reg;
  assign fill_level     = fill_level_reg;

endmodule

// File: tb/tb_circ_frame_fifo.sv
// Directed scoreboard bench for circ_frame_fifo.
module tb_circ_frame_fifo;
  localparam int DW = 36;
`ifdef CIRC_FRAME_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sync_reset_n;
  logic [9:0]    fft_size;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          drop_pulse;
  logic [15:0]   frames_dropped;
  logic [10:0]   fill_level;

  always #5 clk = ~clk;

  circ_frame_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(10)) dut (
    .clk(clk), .sync_reset_n(sync_reset_n), .fft_size(fft_size),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .drop_pulse(drop_pulse),
    .frames_dropped(frames_dropped), .fill_level(fill_level)
  );

  logic [DW:0] sb[$];
  int tests_run = 0, tests_failed = 0, drop_seen = 0, ready_mode = 0;
  bit stall_prev = 1'b0;
  logic [DW:0] hold_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int f, input int b);
    return {4'hA, f[15:0], b[15:0]};
  endfunction

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard pop, AXI hold rule, drop pulse tally.
  always @(negedge clk) begin
    if (!sync_reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (drop_pulse) drop_seen++;
      if (stall_prev) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(hold_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'd0);
        end else begin
          logic [DW:0] exp_beat;
          exp_beat = sb.pop_front();
          check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_beat));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic send_frame(input int fid, input int len, input bit keep, input int gap);
    for (int b = 0; b < len; b++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(fid, b);
      s_axis_tlast  = (b == len - 1);
      if (keep) sb.push_back({s_axis_tlast, s_axis_tdata});
    end
    if (gap > 0) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    check({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
    check({tag, "_drop"},   64'(drop_pulse),    64'd0);
    check({tag, "_fdrop"},  64'(frames_dropped), 64'd0);
    check({tag, "_fill"},   64'(fill_level),    64'd0);
  endtask

  initial begin
    int d0;
    logic [15:0] fd0;
    sync_reset_n  = 1'b0;
    fft_size      = 10'd256;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    sync_reset_n = 1'b1;

    // T1: single 256-beat frame, tvalid must rise 3 edges after the tlast edge
    ready_mode = 1;
    repeat (2) @(posedge clk);
    send_frame(1, 256, 1'b1, 0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_lat_n2", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    check("t1_lat_n3", 64'(m_axis_tvalid), 64'd1);
    wait_drain("t1_drain", 2000);
    check("t1_fill", 64'(fill_level), 64'd0);
    $display("[TB] T1 single frame done");

    // T2: four back-to-back 512-beat frames into a stalled sink
    ready_mode = 0;
    fft_size   = 10'd512;
    repeat (3) @(posedge clk);
    d0 = drop_seen;
    send_frame(10, 512, 1'b1, 0);
    send_frame(11, 512, 1'b1, 0);
    send_frame(12, 512, 1'b0, 0);
    send_frame(13, 512, 1'b0, 5);
    repeat (5) @(negedge clk);
    check("t2_fdrop", 64'(frames_dropped), 64'd2);
    check("t2_pulses", 64'(drop_seen - d0), 64'd2);
    check("t2_fill", 64'(fill_level), 64'd1024);
    ready_mode = 1;
    wait_drain("t2_drain", 3000);
    check("t2_fill_empty", 64'(fill_level), 64'd0);
    $display("[TB] T2 overflow drop done");

    // T3: random backpressure, 20 spaced frames of 128 beats
    ready_mode = 2;
    fft_size   = 10'd128;
    d0 = drop_seen;
    for (int f = 0; f < 20; f++) send_frame(100 + f, 128, 1'b1, 200);
    wait_drain("t3_drain", 8000);
    check("t3_fdrop", 64'(frames_dropped), 64'd2);
    check("t3_pulses", 64'(drop_seen - d0), 64'd0);
    $display("[TB] T3 random backpressure done");

    // T4: reset in the middle of a frame; the partial frame must vanish
    ready_mode = 1;
    fft_size   = 10'd256;
    for (int b = 0; b < 100; b++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(150, b);
      s_axis_tlast  = 1'b0;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    sync_reset_n  = 1'b0;
    @(posedge clk); #1;
    sync_reset_n  = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4_reset");
    send_frame(200, 256, 1'b1, 5);
    wait_drain("t4_drain", 2000);
    check("t4_fdrop", 64'(frames_dropped), 64'd0);
    $display("[TB] T4 mid-frame reset done");

    // T5: short frame followed by a correct one
    fft_size = 10'd64;
    d0 = drop_seen;
    send_frame(300, 60, !LEN_CHECK, 10);
    send_frame(301, 64, 1'b1, 10);
    wait_drain("t5_drain", 2000);
    check("t5_fdrop", 64'(frames_dropped), 64'(LEN_CHECK));
    check("t5_pulses", 64'(drop_seen - d0), 64'(LEN_CHECK));
    $display("[TB] T5 short frame done");

    // T6: fft_size changes mid-frame; next frame uses the new size
    fd0 = frames_dropped;
    fft_size = 10'd128;
    for (int b = 0; b < 128; b++) begin
      @(posedge clk); #1;
      if (b == 10) fft_size = 10'd64;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(400, b);
      s_axis_tlast  = (b == 127);
      sb.push_back({s_axis_tlast, s_axis_tdata});
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(401, 64, 1'b1, 10);
    wait_drain("t6_drain", 2000);
    check("t6_fdrop", 64'(frames_dropped), 64'(fd0));
    $display("[TB] T6 size change done");

    // T7: one-beat frame commits straight from start-of-frame
    fft_size = 10'd1;
    send_frame(500, 1, 1'b1, 10);
    wait_drain("t7_drain", 200);
    check("t7_fdrop", 64'(frames_dropped), 64'(fd0));
    check("t7_fill", 64'(fill_level), 64'd0);
    $display("[TB] T7 single-beat frame done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
